imem_fetch_ctrl: RTL and testbench

Sequencer and two-way arbiter in front of the byte-wide, 64 KiB instruction memory array. It serves word fetches from the processor front end by reading four bytes, most-significant byte first, and assembling one 32-bit instruction. When compiled in, it also shares the same single memory port with a byte-wide program loader/debug port. The block sits between the PC/fetch stage and the instruction memory array, and is the only master of the array's address and write lines.

---
 rtl/imem_fetch_ctrl_pkg.sv | 40 ++++
 rtl/imem_fetch_ctrl_arb.sv | 58 +++++
 rtl/imem_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl_pkg
//   Shared constants and types for the instruction-memory fetch sequencer:
//   state encodings, grant encodings, memory address width, the FSM state
//   record and a small alignment helper.
// ---------------------------------------------------------------------------
package imem_fetch_ctrl_pkg;

    // Byte-address width of the instruction memory array (64 KiB).
    localparam int IMEM_ADDR_W = 16;

    // Number of bytes assembled into one instruction word.
    localparam int IMEM_BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IMEM_S_IDLE  = 2'd0,
        IMEM_S_FETCH = 2'd1,
        IMEM_S_LOAD  = 2'd2,
        IMEM_S_RESP  = 2'd3
    } imem_state_e;

    // Which requester received the most recent grant.
    typedef enum logic {
        IMEM_GNT_FETCH  = 1'b0,
        IMEM_GNT_LOADER = 1'b1
    } imem_gnt_e;

    // Complete sequencer state, kept in one record so the whole FSM can be
    // observed through a single signal.
    typedef struct packed {
        imem_state_e state;
        logic [1:0]  cnt;
    } imem_fsm_t;

    // A word fetch is legal only on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_arb.sv
// ---------------------------------------------------------------------------
// imem_rr_arb
//   Two-request round-robin arbiter. Grants only while en_i is high. On a tie
//   the requester that was not granted last wins; the history register resets
//   to LOADER so the fetch port wins the first tie after reset.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   en_i          arbitration enabled (sequencer idle)
//   fetch_req_i   fetch port request
//   ld_req_i      loader port request
//   gnt_o[1:0]    one-hot grant: [0] fetch, [1] loader (combinational)
// ---------------------------------------------------------------------------
module imem_rr_arb
    import imem_fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       fetch_req_i,
    input  logic       ld_req_i,
    output logic [1:0] gnt_o
);

    imem_gnt_e last_grant_q;
    imem_gnt_e last_grant_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (fetch_req_i && ld_req_i) begin
                gnt_o = (last_grant_q == IMEM_GNT_LOADER) ? 2'b01 : 2'b10;
            end else if (fetch_req_i) begin
                gnt_o = 2'b01;
            end else if (ld_req_i) begin
                gnt_o = 2'b10;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt_o[0]) begin
            last_grant_d = IMEM_GNT_FETCH;
        end else if (gnt_o[1]) begin
            last_grant_d = IMEM_GNT_LOADER;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= IMEM_GNT_LOADER;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//   Sole master of the byte-wide 64 KiB instruction memory. Serves 32-bit
//   instruction fetches by reading four bytes most-significant first, and
//   (when IMEM_LOADER_EN is defined) shares the memory port with a byte-wide
//   loader/debug port through a round-robin arbiter.
//
// Configuration
//   IMEM_LOADER_EN  defined  : loader port and LOAD state present.
//                   undefined: ld_* inputs ignored; ld_gnt_o, ld_done_o,
//                              ld_rdata_o, mem_we_o, mem_wdata_o tied 0.
//
// Handshakes
//   A requester raises its req and holds it, with address/data stable, until
//   the block answers with fetch_ready_o / ld_gnt_o in the same cycle; the
//   inputs are sampled only in that cycle. Completion is a one-cycle pulse
//   (fetch_valid_o / ld_done_o); the result outputs hold until the next
//   completion of the same kind.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   fetch_req_i       fetch request            fetch_addr_i  byte address
//   fetch_ready_o     fetch accepted this cycle
//   fetch_valid_o     result pulse             fetch_instr_o assembled word
//   fetch_err_o       misaligned fetch
//   ld_req_i          loader request           ld_we_i       1=write
//   ld_addr_i         loader address           ld_wdata_i    write byte
//   ld_gnt_o          loader accepted          ld_done_o     loader complete
//   ld_rdata_o        read byte (with ld_done_o)
//   mem_addr_o        array address            mem_we_o      array write
//   mem_wdata_o       array write byte         mem_rdata_i   array read byte
// ---------------------------------------------------------------------------
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              fetch_req_i,
    input  logic [31:0]       fetch_addr_i,
    output logic              fetch_ready_o,
    output logic              fetch_valid_o,
    output logic [31:0]       fetch_instr_o,
    output logic              fetch_err_o,

    input  logic              ld_req_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [7:0]        ld_wdata_i,
    output logic              ld_gnt_o,
    output logic              ld_done_o,
    output logic [7:0]        ld_rdata_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    imem_fsm_t         fsm_q;
    logic [ADDR_W-1:0] base_q;
    logic [23:0]       asm_q;      // first three bytes of the word in flight
    logic [31:0]       instr_q;
    logic              err_q;
    logic              valid_q;

    logic [1:0]        gnt;
    logic              ld_req_eff;
    logic              in_idle;

    // Upper fetch address bits are outside the array and deliberately dropped.
    logic              unused_addr;
    assign unused_addr = ^fetch_addr_i[31:ADDR_W];

    assign in_idle = (fsm_q.state == IMEM_S_IDLE);

`ifdef IMEM_LOADER_EN
    assign ld_req_eff = ld_req_i;
`else
    assign ld_req_eff = 1'b0;
`endif

    imem_rr_arb u_arb (
        .clk         (clk),
        .rst         (rst),
        .en_i        (in_idle),
        .fetch_req_i (fetch_req_i),
        .ld_req_i    (ld_req_eff),
        .gnt_o       (gnt)
    );

    assign fetch_ready_o = gnt[0];
    assign fetch_valid_o = valid_q;
    assign fetch_instr_o = instr_q;
    assign fetch_err_o   = err_q;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= '{state: IMEM_S_IDLE, cnt: 2'd0};
            base_q  <= '0;
            asm_q   <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (fsm_q.state)
                IMEM_S_IDLE: begin
                    if (gnt[0]) begin
                        base_q <= fetch_addr_i[ADDR_W-1:0];
                        if (is_misaligned(fetch_addr_i[1:0])) begin
                            // Rejected without touching memory.
                            instr_q     <= '0;
                            err_q       <= 1'b1;
                            valid_q     <= 1'b1;
                            fsm_q.state <= IMEM_S_RESP;
                        end else begin
                            fsm_q.state <= IMEM_S_FETCH;
                            fsm_q.cnt   <= 2'd0;
                        end
                    end else if (gnt[1]) begin
                        fsm_q.state <= IMEM_S_LOAD;
                    end
                end
                IMEM_S_FETCH: begin
                    asm_q <= {asm_q[15:0], mem_rdata_i};
                    if (fsm_q.cnt == 2'(IMEM_BYTES_PER_WORD - 1)) begin
                        instr_q     <= {asm_q, mem_rdata_i};
                        err_q       <= 1'b0;
                        valid_q     <= 1'b1;
                        fsm_q.state <= IMEM_S_RESP;
                        fsm_q.cnt   <= 2'd0;
                    end else begin
                        fsm_q.cnt <= fsm_q.cnt + 2'd1;
                    end
                end
                IMEM_S_LOAD: begin
                    fsm_q.state <= IMEM_S_IDLE;
                end
                IMEM_S_RESP: begin
                    fsm_q.state <= IMEM_S_IDLE;
                end
                default: begin
                    fsm_q.state <= IMEM_S_IDLE;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_EN
    // ------------------------------------------------------------------
    // Loader request capture and response
    // ------------------------------------------------------------------
    logic              ld_we_q;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [7:0]        ld_wdata_q;
    logic [7:0]        ld_rdata_q;
    logic              ld_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_we_q    <= 1'b0;
            ld_addr_q  <= '0;
            ld_wdata_q <= '0;
            ld_rdata_q <= '0;
            ld_done_q  <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            if (gnt[1]) begin
                ld_we_q    <= ld_we_i;
                ld_addr_q  <= ld_addr_i;
                ld_wdata_q <= ld_wdata_i;
            end
            if (fsm_q.state == IMEM_S_LOAD) begin
                ld_done_q <= 1'b1;
                if (!ld_we_q) begin
                    ld_rdata_q <= mem_rdata_i;
                end
            end
        end
    end

    assign ld_gnt_o   = gnt[1];
    assign ld_done_o  = ld_done_q;
    assign ld_rdata_o = ld_rdata_q;
`else
    logic unused_ld;
    assign unused_ld  = ^{ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, gnt[1]};

    assign ld_gnt_o   = 1'b0;
    assign ld_done_o  = 1'b0;
    assign ld_rdata_o = '0;
`endif

    // ------------------------------------------------------------------
    // Memory port. Parked at address 0 whenever no access is in progress.
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        case (fsm_q.state)
            IMEM_S_FETCH: begin
                mem_addr_o = base_q + ADDR_W'(fsm_q.cnt);
            end
`ifdef IMEM_LOADER_EN
            IMEM_S_LOAD: begin
                mem_addr_o  = ld_addr_q;
                // Reset aborts a pending write even before the state clears.
                mem_we_o    = ld_we_q & ~rst;
                mem_wdata_o = ld_wdata_q;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//   Self-checking bench for imem_fetch_ctrl. Behaves as the byte-wide
//   instruction memory, drives the fetch and loader ports, and checks against
//   expectations derived from the block's rules (byte contents, latencies,
//   round-robin order). Loader checks are compiled in with IMEM_LOADER_EN.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_err;
    logic        ld_req;
    logic        ld_we;
    logic [15:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        ld_gnt;
    logic        ld_done;
    logic [7:0]  ld_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req_i   (fetch_req),
        .fetch_addr_i  (fetch_addr),
        .fetch_ready_o (fetch_ready),
        .fetch_valid_o (fetch_valid),
        .fetch_instr_o (fetch_instr),
        .fetch_err_o   (fetch_err),
        .ld_req_i      (ld_req),
        .ld_we_i       (ld_we),
        .ld_addr_i     (ld_addr),
        .ld_wdata_i    (ld_wdata),
        .ld_gnt_o      (ld_gnt),
        .ld_done_o     (ld_done),
        .ld_rdata_o    (ld_rdata),
        .mem_addr_o    (mem_addr),
        .mem_we_o      (mem_we),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata)
    );

    // ---------------- memory array ----------------
    // Initial contents are a fixed function of address (with the test-plan
    // bytes pinned); bytes written through the port override it.
    logic [7:0] seed;
    bit         wr_valid [0:65535];
    bit [7:0]   wr_data  [0:65535];

    function automatic logic [7:0] init_byte(input logic [15:0] a, input logic [7:0] s);
        case (a)
            16'h0000: return 8'h8C;
            16'h0001: return 8'h01;
            16'h0002: return 8'h00;
            16'h0003: return 8'h04;
            16'hFFFC: return 8'h12;
            16'hFFFD: return 8'h34;
            16'hFFFE: return 8'h56;
            16'hFFFF: return 8'h78;
            default:  return a[7:0] ^ 8'(a[15:8] * 8'd29) ^ s ^ 8'h5A;
        endcase
    endfunction

    assign mem_rdata = wr_valid[mem_addr] ? wr_data[mem_addr] : init_byte(mem_addr, seed);

    always @(posedge clk) begin
        if (mem_we) begin
            wr_valid[mem_addr] <= 1'b1;
            wr_data[mem_addr]  <= mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ld_written [logic [15:0]];
    logic [7:0] last_rd;

    function automatic logic [7:0] ref_byte(input logic [15:0] a);
        if (ld_written.exists(a)) return ld_written[a];
        return init_byte(a, seed);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [15:0] a;
        a = addr[15:0];
        if (addr[1:0] != 2'b00) return 32'h0;
        return {ref_byte(a), ref_byte(a + 16'd1), ref_byte(a + 16'd2), ref_byte(a + 16'd3)};
    endfunction

    // ---------------- scoreboard helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_instr,
                            input logic exp_err, input int exp_lat, input string tag);
        int n;
        logic [15:0] seen[$];
        logic [15:0] want[$];
        logic ok;
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        n = 0;
        @(negedge clk);
        while (!fetch_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(fetch_ready), 32'd1);
        @(posedge clk); #1;
        fetch_req  = 1'b0;
        fetch_addr = $urandom;
        n = 1;
        @(negedge clk);
        seen.push_back(mem_addr);
        while (!fetch_valid && n < 20) begin
            @(negedge clk);
            n++;
            seen.push_back(mem_addr);
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_instr"}, fetch_instr, exp_instr);
        chk({tag, "_err"}, 32'(fetch_err), 32'(exp_err));
        if (exp_err) begin
            want.push_back(16'h0);
        end else begin
            for (int i = 0; i < 4; i++) want.push_back(addr[15:0] + 16'(i));
            want.push_back(16'h0);
        end
        ok = (seen.size() == want.size());
        if (ok) begin
            for (int i = 0; i < want.size(); i++) if (seen[i] !== want[i]) ok = 1'b0;
        end
        chk({tag, "_addr_seq"}, 32'(ok), 32'd1);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(fetch_valid), 32'd0);
        chk({tag, "_hold"}, fetch_instr, exp_instr);
    endtask

`ifdef IMEM_LOADER_EN
    task automatic ld_op(input logic we, input logic [15:0] a, input logic [7:0] d, input string tag);
        int n;
        logic [7:0] exp_rd;
        @(posedge clk); #1;
        ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
        n = 0;
        @(negedge clk);
        while (!ld_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_gnt"}, 32'(ld_gnt), 32'd1);
        @(posedge clk); #1;
        ld_req = 1'b0; ld_we = ~we; ld_addr = ~a; ld_wdata = ~d;
        @(negedge clk);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(we));
        if (we) chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(d));
        exp_rd = we ? last_rd : ref_byte(a);
        @(negedge clk);
        chk({tag, "_done"}, 32'(ld_done), 32'd1);
        chk({tag, "_rdata"}, 32'(ld_rdata), 32'(exp_rd));
        if (we) ld_written[a] = d;
        else    last_rd = exp_rd;
    endtask
`endif

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[5];

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [12:0] rdy_v, vld_v, exp_rdy, exp_vld;
        logic g_q[$];
        logic e_q[$];
        logic last_l;
        logic ok;
        int viol, dbl, coinc;

        vecs[0] = '{32'h0000_0000, 32'h8C01_0004, 1'b0, 5};
        vecs[1] = '{32'h0001_FFFC, 32'h1234_5678, 1'b0, 5};
        vecs[2] = '{32'h0000_0006, 32'h0000_0000, 1'b1, 1};
        vecs[3] = '{32'h0000_0001, 32'h0000_0000, 1'b1, 1};
        vecs[4] = '{32'hFFFF_0003, 32'h0000_0000, 1'b1, 1};

        seed       = 8'($urandom);
        last_rd    = 8'h00;
        rst        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        ld_req     = 1'b0;
        ld_we      = 1'b0;
        ld_addr    = '0;
        ld_wdata   = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(fetch_ready), 32'd0);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_instr", fetch_instr, 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_mem", {15'd0, mem_we, mem_addr}, 32'd0);
        chk("rst_ld", {22'd0, ld_gnt, ld_done, ld_rdata}, 32'd0);
        fetch_req = 1'b1;
        #1;
        chk("rst_ready_req", 32'(fetch_ready), 32'd1);
        fetch_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- table-driven fetches ----
        for (int i = 0; i < 5; i++) begin
            do_fetch(vecs[i].addr, vecs[i].instr, vecs[i].err, vecs[i].lat, $sformatf("vec%0d", i));
        end

`ifdef IMEM_LOADER_EN
        // ---- loader write/read then fetch of the written byte ----
        ld_op(1'b1, 16'h0010, 8'hAB, "ld_wr");
        ld_op(1'b0, 16'h0010, 8'h00, "ld_rd");
        chk("ld_rd_ab", 32'(ld_rdata), 32'h0000_00AB);
        do_fetch(32'h10, ref_word(32'h10), 1'b0, 5, "fetch_ab");
        chk("fetch_ab_msb", 32'(fetch_instr[31:24]), 32'h0000_00AB);
`endif

        // ---- fetch request held continuously: accepts 6 cycles apart ----
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rdy_v[i] = fetch_ready;
            vld_v[i] = fetch_valid;
            exp_rdy[i] = (i % 6 == 0);
            exp_vld[i] = (i % 6 == 5);
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        chk("b2b_ready", 32'(rdy_v), 32'(exp_rdy));
        chk("b2b_valid", 32'(vld_v), 32'(exp_vld));
        repeat (8) @(posedge clk);

        // ---- both requesters held from reset ----
        @(posedge clk); #1;
        rst = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0020; ld_wdata = 8'hEE;
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = 8'h00;
        viol = 0; dbl = 0; coinc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fetch_ready && ld_gnt) dbl++;
            if (fetch_ready) g_q.push_back(1'b0);
            if (ld_gnt) g_q.push_back(1'b1);
            if (fetch_ready && ld_done) coinc++;
`ifndef IMEM_LOADER_EN
            if (ld_gnt || ld_done || mem_we || ld_rdata != 8'h0 || mem_wdata != 8'h0) viol++;
`endif
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        ld_req = 1'b0;
        repeat (10) @(posedge clk);
        // Expected order: loader enabled -> alternate starting with fetch
        // (history starts at LOADER); otherwise the fetch port always wins.
        last_l = 1'b1;
        for (int k = 0; k < 3; k++) begin
`ifdef IMEM_LOADER_EN
            e_q.push_back(last_l ? 1'b0 : 1'b1);
            last_l = ~last_l;
`else
            e_q.push_back(1'b0);
`endif
        end
        ok = (g_q.size() >= 3);
        if (ok) begin
            for (int k = 0; k < 3; k++) if (g_q[k] !== e_q[k]) ok = 1'b0;
        end
        chk("arb_order", 32'(ok), 32'd1);
        chk("arb_double", 32'(dbl), 32'd0);
`ifdef IMEM_LOADER_EN
        chk("arb_done_accept", 32'(coinc > 0), 32'd1);
        last_rd = ref_byte(16'h0020);
`else
        chk("noldr_outputs", 32'(viol), 32'd0);
`endif

        // ---- reset in cycle 2 of a fetch ----
        @(posedge clk); #1;
        fetch_req = 1'b1; fetch_addr = 32'h0000_0004;
        @(negedge clk);
        chk("abort_accept", 32'(fetch_ready), 32'd1);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_outs", {fetch_valid, fetch_ready, fetch_err, 29'd0}, 32'd0);
        chk("abort_instr", fetch_instr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = 8'h00;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fetch_valid) n++;
        end
        chk("abort_no_valid", 32'(n), 32'd0);
        do_fetch(32'h0000_0004, ref_word(32'h4), 1'b0, 5, "refetch");

`ifdef IMEM_LOADER_EN
        // ---- reset during a loader write suppresses the write ----
        @(posedge clk); #1;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0030; ld_wdata = ~ref_byte(16'h0030);
        @(negedge clk);
        chk("wabort_gnt", 32'(ld_gnt), 32'd1);
        @(posedge clk); #1;
        ld_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("wabort_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = 8'h00;
        repeat (3) @(negedge clk);
        chk("wabort_done", 32'(ld_done), 32'd0);
        do_fetch(32'h30, ref_word(32'h30), 1'b0, 5, "wabort_fetch");
`endif

        // ---- randomized traffic ----
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            int op;
            op = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[15:8] = 8'h00;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
`ifdef IMEM_LOADER_EN
            if (op == 0) begin
                ld_op(1'b1, {8'h00, a[7:0]}, 8'($urandom), "rnd_ldw");
            end else if (op == 1) begin
                ld_op(1'b0, {8'h00, a[7:0]}, 8'h00, "rnd_ldr");
            end else begin
                do_fetch(a, ref_word(a), a[1:0] != 2'b00, (a[1:0] != 2'b00) ? 1 : 5, "rnd_fetch");
            end
`else
            if (op == 0) begin
                ld_req = 1'b1; ld_we = 1'b1; ld_addr = a[15:0]; ld_wdata = 8'($urandom);
            end else begin
                ld_req = 1'b0;
            end
            do_fetch(a, ref_word(a), a[1:0] != 2'b00, (a[1:0] != 2'b00) ? 1 : 5, "rnd_fetch");
`endif
        end
        ld_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
